// File: rtl/bpsk_pkg.sv
// Constants, helpers and state type shared by the BPSK modulator and demodulator.
// Both ends of the link import this so their sample and frame geometry agree.
package bpsk_pkg;

    localparam int SAMPLE_NUMBER_DEF = 256;
    localparam int SAMPLE_WIDTH_DEF  = 12;
    localparam int DATA_WIDTH_DEF    = 12;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_ACC  = 1'b1
    } state_e;

    function automatic int midscale(input int sample_width);
        return 1 << (sample_width - 1);
    endfunction

    // Enough headroom for a full symbol of worst-case samples of one polarity.
    function automatic int acc_width(input int sample_width, input int sample_number);
        return sample_width + 1 + $clog2(sample_number);
    endfunction

endpackage

// File: rtl/bpsk_demodulator_if.sv
// Sample-in / codeword-out bundle of the BPSK demodulator.
interface bpsk_demodulator_if #(
    parameter int SAMPLE_WIDTH = bpsk_pkg::SAMPLE_WIDTH_DEF,
    parameter int DATA_WIDTH   = bpsk_pkg::DATA_WIDTH_DEF
) ();
    logic                    en;
    logic [SAMPLE_WIDTH-1:0] signal_in;
    logic                    busy;
    logic                    dv;
    logic                    abort;
    logic [DATA_WIDTH-1:0]   q;

    modport master (output en, output signal_in, input busy, input dv, input abort, input q);
    modport slave  (input en, input signal_in, output busy, output dv, output abort, output q);
endinterface

// File: rtl/bpsk_correlator.sv
// Correlates each symbol period against a square-wave carrier and slices one bit.
// bit_valid/bit_out are combinational so the decision lands on the last sample's edge.
module bpsk_correlator
    import bpsk_pkg::*;
#(
    parameter int SAMPLE_NUMBER = SAMPLE_NUMBER_DEF,
    parameter int SAMPLE_WIDTH  = SAMPLE_WIDTH_DEF
) (
    input  logic                    clk,
    input  logic                    arst,
    input  logic                    en,
    input  logic                    clear,
    input  logic [SAMPLE_WIDTH-1:0] signal_in,
    output logic                    bit_valid,
    output logic                    bit_out
);
    localparam int CW  = $clog2(SAMPLE_NUMBER);
    localparam int AW  = acc_width(SAMPLE_WIDTH, SAMPLE_NUMBER);
    localparam int MID = midscale(SAMPLE_WIDTH);

    logic [CW-1:0]           cnt_q, cnt_d;
    logic signed [AW-1:0]    acc_q, acc_d;
    logic signed [AW-1:0]    acc_sum;
    logic signed [AW-1:0]    d_ext;
    logic signed [SAMPLE_WIDTH:0] d;

    always_comb begin
        d       = $signed({1'b0, signal_in}) - $signed((SAMPLE_WIDTH + 1)'(MID));
        d_ext   = {{(AW - SAMPLE_WIDTH - 1){d[SAMPLE_WIDTH]}}, d};
        // Counter MSB marks the second half-period, where the reference is negative.
        acc_sum = cnt_q[CW-1] ? (acc_q - d_ext) : (acc_q + d_ext);
        bit_valid = en && (&cnt_q);
        bit_out   = ~acc_sum[AW-1];

        cnt_d = cnt_q;
        acc_d = acc_q;
        if (clear) begin
            cnt_d = '0;
            acc_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = bit_valid ? '0 : acc_sum;
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            cnt_q <= '0;
            acc_q <= '0;
        end else begin
            cnt_q <= cnt_d;
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/bpsk_demodulator.sv
// BPSK demodulator: frame FSM, symbol counter and codeword shift register around
// the carrier correlator. Emits one codeword per DATA_WIDTH symbols with a dv strobe.
module bpsk_demodulator
    import bpsk_pkg::*;
#(
    parameter int SAMPLE_NUMBER = SAMPLE_NUMBER_DEF,
    parameter int SAMPLE_WIDTH  = SAMPLE_WIDTH_DEF,
    parameter int DATA_WIDTH    = DATA_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                arst,
    bpsk_demodulator_if.slave   bus
);
    localparam int SYW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_e                state_q, state_d;
    logic [SYW-1:0]        sym_q, sym_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic [DATA_WIDTH-1:0] q_q, q_d;
    logic                  busy_q, busy_d;
    logic                  dv_q, dv_d;
    logic                  abort_q, abort_d;
    logic                  bit_valid, bit_out;
    logic                  clear;

    // Clearing on the same cycle en drops lets a new frame start right behind an abort.
    assign clear = (state_q == ST_ACC) && !bus.en;

    bpsk_correlator #(
        .SAMPLE_NUMBER (SAMPLE_NUMBER),
        .SAMPLE_WIDTH  (SAMPLE_WIDTH)
    ) u_correlator (
        .clk       (clk),
        .arst      (arst),
        .en        (bus.en),
        .clear     (clear),
        .signal_in (bus.signal_in),
        .bit_valid (bit_valid),
        .bit_out   (bit_out)
    );

    always_comb begin
        state_d = state_q;
        sym_d   = sym_q;
        shreg_d = shreg_q;
        q_d     = q_q;
        busy_d  = busy_q;
        dv_d    = 1'b0;
        abort_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (bus.en) begin
                    state_d = ST_ACC;
                    busy_d  = 1'b1;
                end
            end
            ST_ACC: begin
                if (!bus.en) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    abort_d = 1'b1;
                    sym_d   = '0;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (bit_valid) begin
            shreg_d = {shreg_q[DATA_WIDTH-2:0], bit_out};
            if (sym_q == SYW'(DATA_WIDTH - 1)) begin
                q_d     = shreg_d;
                dv_d    = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                sym_d   = '0;
            end else begin
                sym_d = sym_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            state_q <= ST_IDLE;
            sym_q   <= '0;
            shreg_q <= '0;
            q_q     <= '0;
            busy_q  <= 1'b0;
            dv_q    <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            sym_q   <= sym_d;
            shreg_q <= shreg_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            dv_q    <= dv_d;
            abort_q <= abort_d;
        end
    end

    assign bus.busy  = busy_q;
    assign bus.dv    = dv_q;
    assign bus.abort = abort_q;
    assign bus.q     = q_q;

endmodule

// File: tb/tb_bpsk_demodulator.sv
// Self-checking bench for bpsk_demodulator: waveform frames with a summation-based
// reference model of the per-symbol correlation and slicing.
module tb_bpsk_demodulator;
    localparam int SN    = 256;
    localparam int SW    = 12;
    localparam int DW    = 12;
    localparam int FRAME = SN * DW;

    logic clk = 1'b0;
    logic arst;
    int   cyc = 0;
    int   errs = 0;
    int   checks = 0;

    logic [DW-1:0] dv_vals[$];
    int            dv_cycs[$];
    int            abort_cycs[$];
    int            last_cyc;

    bpsk_demodulator_if #(.SAMPLE_WIDTH(SW), .DATA_WIDTH(DW)) bus ();

    bpsk_demodulator #(
        .SAMPLE_NUMBER (SN),
        .SAMPLE_WIDTH  (SW),
        .DATA_WIDTH    (DW)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (arst) begin
            if (bus.dv) begin
                dv_vals.push_back(bus.q);
                dv_cycs.push_back(cyc);
                chk("busy_low_at_dv", {31'd0, bus.busy}, 32'd0);
                chk("dv_abort_exclusive", {31'd0, bus.abort}, 32'd0);
            end
            if (bus.abort) begin
                abort_cycs.push_back(cyc);
                chk("busy_low_at_abort", {31'd0, bus.busy}, 32'd0);
            end
        end
    end

    task automatic clear_log();
        dv_vals.delete();
        dv_cycs.delete();
        abort_cycs.delete();
    endtask

    // Builds the frame waveform, predicts the codeword from it, then drives it.
    task automatic run_frame(input logic [DW-1:0] word, input bit mid, input int noise,
                             input int stop_at, output logic [DW-1:0] exp_q);
        int   fr [FRAME];
        int   v;
        int   a;
        int   n_drive;
        logic b;
        for (int i = 0; i < DW; i++) begin
            b = word[DW-1-i];
            for (int k = 0; k < SN; k++) begin
                v = mid ? 2048 : ((((k < SN/2) ? 1'b1 : 1'b0) == b) ? 4095 : 0);
                if (noise > 0) v += int'($urandom_range(2*noise, 0)) - noise;
                if (v < 0) v = 0;
                if (v > 4095) v = 4095;
                fr[i*SN + k] = v;
            end
        end
        exp_q = '0;
        for (int i = 0; i < DW; i++) begin
            a = 0;
            for (int k = 0; k < SN; k++)
                a += (k < SN/2) ? (fr[i*SN+k] - 2048) : (2048 - fr[i*SN+k]);
            exp_q[DW-1-i] = (a >= 0);
        end
        n_drive = (stop_at < 0) ? FRAME : stop_at;
        for (int n = 0; n < n_drive; n++) begin
            @(negedge clk);
            bus.en        = 1'b1;
            bus.signal_in = SW'(fr[n]);
            last_cyc      = cyc;
            if (n == 1500) chk("busy_mid_frame", {31'd0, bus.busy}, 32'd1);
        end
    endtask

    task automatic idle_cycles(input int n);
        @(negedge clk);
        bus.en = 1'b0;
        bus.signal_in = '0;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [DW-1:0] e0, e1, ed;
        int brk;
        arst = 1'b0;
        bus.en = 1'b0;
        bus.signal_in = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("rst_dv", {31'd0, bus.dv}, 32'd0);
        chk("rst_abort", {31'd0, bus.abort}, 32'd0);
        chk("rst_q", 32'(bus.q), 32'd0);
        arst = 1'b1;
        @(negedge clk);

        // ideal frame
        clear_log();
        run_frame(12'hB3A, 1'b0, 0, -1, e0);
        idle_cycles(4);
        chk("t1_dv_count", dv_vals.size(), 1);
        if (dv_vals.size() >= 1) begin
            chk("t1_q_model", 32'(dv_vals[0]), 32'(e0));
            chk("t1_q_word", 32'(dv_vals[0]), 32'h0B3A);
            chk("t1_dv_latency", dv_cycs[0], last_cyc + 1);
        end
        chk("t1_busy_after", {31'd0, bus.busy}, 32'd0);
        chk("t1_q_held", 32'(bus.q), 32'h0B3A);

        // midscale ties
        clear_log();
        run_frame(12'h000, 1'b1, 0, -1, e0);
        idle_cycles(4);
        chk("t2_dv_count", dv_vals.size(), 1);
        if (dv_vals.size() >= 1) chk("t2_q_tie", 32'(dv_vals[0]), 32'h0FFF);

        // back-to-back frames
        clear_log();
        run_frame(12'h000, 1'b0, 0, -1, e0);
        run_frame(12'hFFF, 1'b0, 0, -1, e1);
        idle_cycles(4);
        chk("t3_dv_count", dv_vals.size(), 2);
        if (dv_vals.size() >= 2) begin
            chk("t3_q0", 32'(dv_vals[0]), 32'h000);
            chk("t3_q1", 32'(dv_vals[1]), 32'hFFF);
            chk("t3_spacing", dv_cycs[1] - dv_cycs[0], FRAME);
        end
        chk("t3_abort_none", abort_cycs.size(), 0);

        // abort at sample 1000, then fresh frame
        clear_log();
        run_frame(12'h777, 1'b0, 0, 1000, ed);
        @(negedge clk);
        bus.en = 1'b0;
        brk = cyc;
        run_frame(12'h5A5, 1'b0, 0, -1, e0);
        idle_cycles(4);
        chk("t4_abort_count", abort_cycs.size(), 1);
        if (abort_cycs.size() >= 1) chk("t4_abort_time", abort_cycs[0], brk + 1);
        chk("t4_dv_count", dv_vals.size(), 1);
        if (dv_vals.size() >= 1) chk("t4_q", 32'(dv_vals[0]), 32'h5A5);

        // noisy frame
        clear_log();
        run_frame(12'h3C3, 1'b0, 600, -1, e0);
        idle_cycles(4);
        chk("t5_dv_count", dv_vals.size(), 1);
        if (dv_vals.size() >= 1) begin
            chk("t5_q_model", 32'(dv_vals[0]), 32'(e0));
            chk("t5_q_word", 32'(dv_vals[0]), 32'h3C3);
        end

        // reset mid-frame
        clear_log();
        run_frame(12'hABC, 1'b0, 0, 2000, ed);
        chk("t6_busy_before", {31'd0, bus.busy}, 32'd1);
        arst = 1'b0;
        bus.en = 1'b0;
        #1;
        chk("t6_rst_busy", {31'd0, bus.busy}, 32'd0);
        chk("t6_rst_dv", {31'd0, bus.dv}, 32'd0);
        chk("t6_rst_abort", {31'd0, bus.abort}, 32'd0);
        chk("t6_rst_q", 32'(bus.q), 32'd0);
        repeat (3) @(negedge clk);
        arst = 1'b1;
        run_frame(12'h8F1, 1'b0, 0, -1, e0);
        idle_cycles(4);
        chk("t6_abort_none", abort_cycs.size(), 0);
        chk("t6_dv_count", dv_vals.size(), 1);
        if (dv_vals.size() >= 1) chk("t6_q", 32'(dv_vals[0]), 32'h8F1);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
